// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and a future receiver).
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } par_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_prescale(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs while enabled, pulses tick_o on the last clock of each bit.
module uart_baud_tick #(
    parameter int PRESCALE = 217
) (
    input  logic clk_i,
    input  logic nReset_i,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            cnt_q <= '0;
        end else if (restart_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: 5..9 data bits, optional parity, 1 or 2 stop bits.
//   state     | meaning
//   ST_IDLE   | line high, ready for a word
//   ST_START  | start bit (low)
//   ST_DATA   | data bits, LSB first
//   ST_PARITY | parity bit
//   ST_STOP   | stop bit(s), high
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 230_400,
    parameter int DATA_LEN  = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int PRESCALE  = calc_prescale(CLK_HZ, BAUD)
) (
    input  logic                clk_i,
    input  logic                nReset_i,
    input  logic                valid_i,
    input  logic [DATA_LEN-1:0] data_i,
    output logic                ready_o,
    output logic                Tx_o,
    output logic                busy_o,
    output logic                done_o
);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("uart_tx_frame: PRESCALE must be at least 2");
    end
    if (DATA_LEN < 5 || DATA_LEN > 9) begin : g_bad_data_len
        $error("uart_tx_frame: DATA_LEN must be 5..9");
    end
    if (PARITY < int'(PAR_NONE) || PARITY > int'(PAR_EVEN)) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0..2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam bit           HAS_PARITY = (PARITY != int'(PAR_NONE));
    localparam logic [3:0]   LAST_BIT   = 4'(DATA_LEN - 1);
    localparam logic         LAST_STOP  = 1'(STOP_BITS - 1);

    tx_state_t             state_q;
    logic [DATA_LEN-1:0]   shift_q;
    logic [3:0]            bit_cnt_q;
    logic                  stop_cnt_q;
    logic                  par_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  accept;
    logic                  tick;
    logic                  par_d;

    assign ready_o = (state_q == ST_IDLE);
    assign accept  = valid_i && ready_o;
    assign par_d   = (PARITY == int'(PAR_ODD)) ? ~^data_i : ^data_i;

    uart_baud_tick #(
        .PRESCALE (PRESCALE)
    ) u_baud_tick (
        .clk_i     (clk_i),
        .nReset_i  (nReset_i),
        .restart_i (accept),
        .en_i      (state_q != ST_IDLE),
        .tick_o    (tick)
    );

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q <= data_i;
                        par_q   <= par_d;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            if (HAS_PARITY) begin
                                tx_q    <= par_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                state_q    <= ST_STOP;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt_q == LAST_STOP) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
